align_result_serializer: RTL and testbench

Downstream of the max-score register stage. When the alignment controller signals that the last matrix cell has been compared, this block captures the final {max_score, max_row, max_col} triple. It packs the triple into one word and streams it off-chip as narrow LSB-first beats over a valid/ready handshake. Its purpose is to reduce result pin count; it does not change the values.

---
 rtl/align_result_serializer.sv | 133 +++++++++++++
 tb/tb_align_result_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/align_result_serializer.sv
// align_result_serializer
//
// Captures the final {max_score, max_row, max_col} triple when the alignment
// controller reports that the last matrix cell has been compared. The triple
// is packed into one word and streamed out as LSB-first beats of OUT_WIDTH
// bits over a valid/ready handshake. The values are not modified.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : new-alignment pulse; synchronous clear/abort, highest priority
//   done_in    : single-cycle pulse; max_* inputs are final in this cycle
//   max_score  : final max score
//   max_row    : row index of the max score
//   max_col    : column index of the max score
//   out_data   : current beat (LSB-first slice of the packed word)
//   out_valid  : out_data is valid
//   out_ready  : sink accepts the beat when out_valid is also high
//   out_last   : high with the final beat of a result
//   busy       : high while a result is being streamed
//   overrun    : sticky; set when done_in arrives while busy, cleared by start
module align_result_serializer #(
  parameter int SCORE_WIDTH    = 10,
  parameter int ROW_BITS_WIDTH = 5,
  parameter int COL_BITS_WIDTH = 5,
  parameter int OUT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      done_in,
  input  logic [SCORE_WIDTH-1:0]    max_score,
  input  logic [ROW_BITS_WIDTH-1:0] max_row,
  input  logic [COL_BITS_WIDTH-1:0] max_col,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int PACK_WIDTH  = SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
  localparam int NUM_BEATS   = (PACK_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int SHIFT_WIDTH = NUM_BEATS * OUT_WIDTH;
  localparam int CNT_WIDTH   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                 state_q,   state_d;
  logic [SHIFT_WIDTH-1:0] shift_q,   shift_d;
  logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
  logic                   overrun_q, overrun_d;

  logic [PACK_WIDTH-1:0]  packed_word;
  logic                   is_last;

  // max_col occupies the least significant bits, so it leaves in beat 0.
  assign packed_word = {max_score, max_row, max_col};
  assign is_last     = (state_q == SEND) && (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // case/if tree leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    if (start) begin
      // Abort wins over capture and transfer; a concurrent done_in is dropped
      // without counting as overrun.
      state_d   = IDLE;
      shift_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (done_in) begin
            shift_d = SHIFT_WIDTH'(packed_word);
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          // The in-flight stream is never disturbed by a new result.
          if (done_in) begin
            overrun_d = 1'b1;
          end
          if (out_ready) begin
            if (is_last) begin
              state_d = IDLE;
            end else begin
              shift_d = shift_q >> OUT_WIDTH;
              cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode registered state only; nothing here looks at out_ready or
  // done_in, so the handshake has no combinational path through this block.
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = is_last;
  assign out_data  = (state_q == SEND) ? shift_q[OUT_WIDTH-1:0] : '0;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_align_result_serializer.sv
// Testbench for align_result_serializer (default parameters).
// A queue-based model holds the beats still owed to the sink; a compare
// process checks every DUT output against it on each falling edge.
module tb_align_result_serializer;

  localparam int SW = 10;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int OW = 8;
  localparam int NB = (SW + RW + CW + OW - 1) / OW;

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst_n;
  logic          start;
  logic          done_in;
  logic [SW-1:0] max_score;
  logic [RW-1:0] max_row;
  logic [CW-1:0] max_col;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;

  int tests = 0;
  int fails = 0;

  align_result_serializer #(
    .SCORE_WIDTH   (SW),
    .ROW_BITS_WIDTH(RW),
    .COL_BITS_WIDTH(CW),
    .OUT_WIDTH     (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .done_in  (done_in),
    .max_score(max_score),
    .max_row  (max_row),
    .max_col  (max_col),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Clock keeps its phase while stopped so it can be frozen for the reset test.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] pack_word(input int s, input int r, input int c);
    return 32'(s * (1 << (RW + CW)) + r * (1 << CW) + c);
  endfunction

  logic [OW-1:0] exp_q[$];
  bit            exp_ovr;
  bit            was_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      was_busy = (exp_q.size() != 0);
      if (start) begin
        exp_q.delete();
        exp_ovr = 1'b0;
      end else begin
        if (done_in) begin
          if (was_busy) exp_ovr = 1'b1;
          else begin
            logic [31:0] w;
            w = pack_word(int'(max_score), int'(max_row), int'(max_col));
            for (int i = 0; i < NB; i++) exp_q.push_back(OW'(w >> (OW * i)));
          end
        end
        if (was_busy && out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("busy",      32'(busy),      32'(exp_q.size() != 0));
      check("out_last",  32'(out_last),  32'(exp_q.size() == 1));
      check("overrun",   32'(overrun),   32'(exp_ovr));
      if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    end
  end

  // Beats the sink accepts (out_ready is stable from posedge+2 to the next edge).
  logic [OW-1:0] got[$];
  bit            got_last[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_done(input int s, input int r, input int c);
    max_score = SW'(s);
    max_row   = RW'(r);
    max_col   = CW'(c);
    done_in   = 1'b1;
    tick();
    done_in   = 1'b0;
  endtask

  task automatic clear_got();
    got.delete();
    got_last.delete();
  endtask

  task automatic check_beats(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    check({nm, "_count"}, 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check({nm, "_b0"}, 32'(got[0]), 32'(e0));
      check({nm, "_b1"}, 32'(got[1]), 32'(e1));
      check({nm, "_b2"}, 32'(got[2]), 32'(e2));
      check({nm, "_last"}, {29'd0, got_last[0], got_last[1], got_last[2]}, 32'b001);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; done_in = 1'b0; out_ready = 1'b0;
    max_score = '0; max_row = '0; max_col = '0;
    #12;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_data",    32'(out_data),  32'd0);
    check("rst_last",    32'(out_last),  32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    #11 rst_n = 1'b1;
    tick();

    check("model_pack", pack_word(32'h2A5, 32'h13, 32'h0B), 32'hA966B);

    // Basic stream
    clear_got();
    out_ready = 1'b1;
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    check("basic_valid_latency", 32'(out_valid), 32'd1);
    repeat (NB) tick();
    check("basic_idle_valid", 32'(out_valid), 32'd0);
    check("basic_idle_busy",  32'(busy),      32'd0);
    check_beats("basic", 8'h6B, 8'h96, 8'h0A);

    // Backpressure: 4 stalled cycles per beat
    clear_got();
    out_ready = 1'b0;
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    for (int b = 0; b < NB; b++) begin
      out_ready = 1'b0;
      repeat (4) tick();
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    repeat (3) tick();
    check_beats("bp", 8'h6B, 8'h96, 8'h0A);

    // Overrun during beat 1
    clear_got();
    out_ready = 1'b1;
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    tick();
    pulse_done(10'h001, 5'h13, 5'h0B);
    repeat (5) tick();
    check("ovr_flag", 32'(overrun), 32'd1);
    check_beats("ovr", 8'h6B, 8'h96, 8'h0A);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Start abort while beat 1 is being accepted
    clear_got();
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    repeat (2) tick();
    check("abort_no_last", 32'(got_last.size() == 2 && !got_last[0] && !got_last[1]), 32'd1);
    clear_got();
    pulse_done(10'h3FF, 5'h1F, 5'h1F);
    repeat (NB + 1) tick();
    check_beats("full", 8'hFF, 8'hFF, 8'h0F);

    // Start together with done_in while idle
    start = 1'b1;
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    start = 1'b0;
    tick();
    check("startdone_valid",   32'(out_valid), 32'd0);
    check("startdone_overrun", 32'(overrun),   32'd0);

    // Asynchronous reset mid beat 2 with the clock frozen
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    tick();
    tick();
    check("pre_reset_last", 32'(out_last), 32'd1);
    clk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  32'(out_data),  32'd0);
    check("arst_last",  32'(out_last),  32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    #3 rst_n = 1'b1;
    #1 clk_en = 1'b1;
    tick();
    check("post_reset_idle", 32'(out_valid), 32'd0);
    clear_got();
    pulse_done(10'h2A5, 5'h13, 5'h0B);
    repeat (NB + 1) tick();
    check_beats("post_reset", 8'h6B, 8'h96, 8'h0A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
